// File: rtl/sort_sequencer_if.sv
// Valid/ready stream pair for the sort sequencer: unsorted samples in, sorted elements out.
// The master side is the producer/consumer; the slave side is the sequencer.
interface sort_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/sort_sequencer.sv
// In-place bubble sorter over N 4-bit values: one compare per cycle with early exit,
// loaded and drained over valid/ready streams.
module sort_sequencer #(
  parameter int unsigned N      = 8,
  parameter bit          ASCEND = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  sort_sequencer_if.slave   bus,
  output logic              busy,
  output logic [7:0]        sort_cycles
);

  localparam int unsigned   IdxW    = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [IdxW-1:0] PassEnd = IdxW'(N - 2);

  typedef enum logic [1:0] {StLoad, StSort, StDrain} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] pass_q, pass_d;
  logic            swapped_q, swapped_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      sort_cycles_q, sort_cycles_d;
  logic [3:0]      mem_q [N];
  logic [3:0]      mem_d [N];

  logic [IdxW-1:0] idx_nxt;
  logic [3:0]      elem_a, elem_b;
  logic            a_gt_b, a_lt_b, do_swap;
  logic [7:0]      cnt_inc;

  // Shared compare of the adjacent pair selected by idx
  always_comb begin
    idx_nxt = idx_q + IdxW'(1);
    elem_a  = mem_q[idx_q];
    elem_b  = mem_q[idx_nxt];
    a_gt_b  = elem_a > elem_b;
    a_lt_b  = elem_a < elem_b;
    do_swap = ASCEND ? a_gt_b : a_lt_b;
    cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    pass_d        = pass_q;
    swapped_d     = swapped_q;
    cnt_d         = cnt_q;
    sort_cycles_d = sort_cycles_q;
    mem_d         = mem_q;
    unique case (state_q)
      StLoad: begin
        if (bus.in_valid) begin
          mem_d[idx_q] = bus.in_data;
          if (idx_q == LastIdx) begin
            idx_d     = '0;
            pass_d    = '0;
            swapped_d = 1'b0;
            cnt_d     = '0;
            state_d   = StSort;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      StSort: begin
        cnt_d = cnt_inc;
        if (do_swap) begin
          mem_d[idx_q]   = elem_b;
          mem_d[idx_nxt] = elem_a;
          swapped_d      = 1'b1;
        end
        if (idx_q == PassEnd) begin
          idx_d = '0;
          // Early exit once a full pass is swap-free, including this cycle's compare
          if (!(swapped_q || do_swap) || (pass_q == PassEnd)) begin
            state_d       = StDrain;
            sort_cycles_d = cnt_inc;
          end else begin
            pass_d    = pass_q + IdxW'(1);
            swapped_d = 1'b0;
          end
        end else begin
          idx_d = idx_nxt;
        end
      end
      StDrain: begin
        if (bus.out_ready) begin
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StLoad;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StLoad;
      idx_q         <= '0;
      pass_q        <= '0;
      swapped_q     <= 1'b0;
      cnt_q         <= '0;
      sort_cycles_q <= '0;
      for (int i = 0; i < N; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      pass_q        <= pass_d;
      swapped_q     <= swapped_d;
      cnt_q         <= cnt_d;
      sort_cycles_q <= sort_cycles_d;
      mem_q         <= mem_d;
    end
  end

  assign bus.in_ready  = (state_q == StLoad);
  assign bus.out_valid = (state_q == StDrain);
  assign bus.out_data  = (state_q == StDrain) ? mem_q[idx_q] : 4'd0;
  assign busy          = (state_q != StLoad);
  assign sort_cycles   = sort_cycles_q;

endmodule

// File: tb/tb_sort_sequencer.sv
// Scoreboard bench for sort_sequencer: an ascending and a descending instance share
// one set of stream drivers, selected by sel.
module tb_sort_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       sel;
  logic       drv_valid;
  logic [3:0] drv_data;
  logic       drv_ready;

  sort_sequencer_if a_if ();
  sort_sequencer_if d_if ();

  logic       a_busy, d_busy;
  logic [7:0] a_cyc, d_cyc;

  sort_sequencer #(.N(8), .ASCEND(1'b1)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (a_if),
    .busy        (a_busy),
    .sort_cycles (a_cyc)
  );

  sort_sequencer #(.N(8), .ASCEND(1'b0)) dut_d (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (d_if),
    .busy        (d_busy),
    .sort_cycles (d_cyc)
  );

  assign a_if.in_valid  = drv_valid & ~sel;
  assign d_if.in_valid  = drv_valid & sel;
  assign a_if.in_data   = drv_data;
  assign d_if.in_data   = drv_data;
  assign a_if.out_ready = drv_ready & ~sel;
  assign d_if.out_ready = drv_ready & sel;

  logic       m_in_ready, m_out_valid, m_busy;
  logic [3:0] m_out_data;
  logic [7:0] m_cyc;
  assign m_in_ready  = sel ? d_if.in_ready  : a_if.in_ready;
  assign m_out_valid = sel ? d_if.out_valid : a_if.out_valid;
  assign m_out_data  = sel ? d_if.out_data  : a_if.out_data;
  assign m_busy      = sel ? d_busy         : a_busy;
  assign m_cyc       = sel ? d_cyc          : a_cyc;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  job[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Push the expected output order, then stream the job in (called at a negedge)
  task automatic send_job(input logic [3:0] vals[8]);
    logic [3:0] s[8];
    logic [3:0] t;
    int n;
    s = vals;
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        if (sel ? (s[j] > s[i]) : (s[j] < s[i])) begin
          t = s[i]; s[i] = s[j]; s[j] = t;
        end
      end
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(s[i]);
    for (int i = 0; i < 8; i++) begin
      drv_valid = 1'b1;
      drv_data  = vals[i];
      n = 0;
      while (m_in_ready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("in_ready_load", m_in_ready, 1);
      @(negedge clk);
    end
    drv_valid = 1'b0;
  endtask

  // mode 0: out_ready always high; mode 1: out_ready follows 1,0,0,1,0,1 repeating
  task automatic drain(input int mode, input int exp_cyc, input int exp_busy);
    bit pat[6];
    int busy_n;
    int k;
    int guard;
    pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    busy_n = 0;
    k      = 0;
    guard  = 0;
    while (exp_q.size() > 0 && guard < 600) begin
      guard++;
      if (m_busy === 1'b1) busy_n++;
      check("in_ready_busy", m_in_ready, 0);
      if (m_out_valid === 1'b1) begin
        drv_ready = (mode == 0) ? 1'b1 : pat[k % 6];
        k++;
        check("out_data", m_out_data, exp_q[0]);
        if (drv_ready) void'(exp_q.pop_front());
      end else begin
        drv_ready = (mode == 0);
      end
      @(negedge clk);
    end
    drv_ready = 1'b0;
    check("drain_left", exp_q.size(), 0);
    check("busy_after", m_busy, 0);
    check("in_ready_after", m_in_ready, 1);
    check("out_valid_after", m_out_valid, 0);
    check("sort_cycles", m_cyc, exp_cyc);
    check("busy_cycles", busy_n, exp_busy);
  endtask

  initial begin
    rst_n     = 1'b0;
    sel       = 1'b0;
    drv_valid = 1'b0;
    drv_data  = 4'd0;
    drv_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", m_in_ready, 1);
    check("rst_out_valid", m_out_valid, 0);
    check("rst_busy", m_busy, 0);
    check("rst_out_data", m_out_data, 0);
    check("rst_sort_cycles", m_cyc, 0);

    // Already sorted: a single pass
    job = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    send_job(job);
    drain(0, 7, 15);

    // Reverse order: worst case
    job = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    send_job(job);
    drain(0, 49, 57);

    // Duplicates: equal pairs never swap, six passes
    job = '{4'd5, 4'd3, 4'd5, 4'd0, 4'hF, 4'd3, 4'd0, 4'hF};
    send_job(job);
    drain(0, 42, 50);

    // Reverse order with a stalling consumer
    job = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    send_job(job);
    drain(1, 49, 65);

    // Reset on SORT cycle 10
    job = '{4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    send_job(job);
    repeat (9) @(negedge clk);
    check("pre_rst_busy", m_busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    check("mid_rst_in_ready", m_in_ready, 1);
    check("mid_rst_out_valid", m_out_valid, 0);
    check("mid_rst_busy", m_busy, 0);
    check("mid_rst_sort_cycles", m_cyc, 0);
    job = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    send_job(job);
    drain(0, 7, 15);

    // Descending instance
    sel = 1'b1;
    @(negedge clk);
    job = '{4'd2, 4'd9, 4'd1, 4'd9, 4'd0, 4'd4, 4'd7, 4'd3};
    send_job(job);
    drain(0, 35, 43);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
